ifu_pc_fetch: RTL



---
 rtl/mips_pkg.sv | 15 +
 rtl/pc_reg.sv | 21 ++
 rtl/ifu_pc_fetch.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: fetch FSM state encoding and reset/NOP constants.
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    HALT  = 3'd4
  } ifu_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Architectural PC register: async active-low reset to RESET_VAL, loads d when load is high.
module pc_reg #(
  parameter int               W         = 32,
  parameter logic [W-1:0]     RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ifu_pc_fetch.sv
// Fetch stage: owns the PC, fetches over req/gnt/rvalid and holds the instruction for decode.
// Optional macro IFU_MISALIGN_CHK_EN adds a sticky misalign_o flag and a HALT state.
module ifu_pc_fetch
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] npc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
`ifdef IFU_MISALIGN_CHK_EN
  output logic              misalign_o,
`endif
  output ifu_state_t        state_o
);

  // Handshakes: the request is held with a stable address until imem_gnt_i is seen
  // in REQ; imem_rvalid_i counts only in WAIT; inst_o transfers on the cycle where
  // inst_valid_o && inst_ready_i, and stays frozen while inst_ready_i is low.

  ifu_state_t        state_q, state_d;
  logic              pc_load;
  logic              inst_load;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       inst_q;
`ifdef IFU_MISALIGN_CHK_EN
  logic              misalign_set;
  logic              misalign_q;
`endif

  pc_reg #(
    .W         (ADDR_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_load),
    .d     (npc_i),
    .q     (pc_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_load   = 1'b0;
    inst_load = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    misalign_set = 1'b0;
`endif
    case (state_q)
      IDLE: state_d = REQ;
      // A same-cycle rvalid is ignored here; the memory never answers with zero latency.
      REQ: begin
        if (imem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          inst_load = 1'b1;
          state_d   = VALID;
        end
      end
      VALID: begin
        if (inst_ready_i) begin
          pc_load = 1'b1;
          state_d = REQ;
`ifdef IFU_MISALIGN_CHK_EN
          if (npc_i[1:0] != 2'b00) begin
            misalign_set = 1'b1;
            state_d      = HALT;
          end
`endif
        end
      end
`ifdef IFU_MISALIGN_CHK_EN
      HALT: state_d = HALT;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q <= INST_NOP;
    end else if (inst_load) begin
      inst_q <= imem_rdata_i;
    end
  end

`ifdef IFU_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (misalign_set) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_o = misalign_q;
`endif

  assign pc_o         = pc_q;
  assign imem_addr_o  = pc_q;
  assign imem_req_o   = (state_q == REQ);
  assign inst_o       = inst_q;
  assign inst_valid_o = (state_q == VALID);
  assign state_o      = state_q;

endmodule
